// File: rtl/riscv_32i_defs_pkg.sv
// ============================================================================
// Module : riscv_32i_defs_pkg
// Brief  : Shared RV32I register-file types plus the write-port command type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_32i_defs_pkg;

    localparam int XLEN          = 32;
    localparam int RF_ADDR_WIDTH = 5;

    typedef logic [XLEN-1:0]          word_t;
    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

    localparam rf_addr_t X0             = '0;
    localparam word_t    WORD_ALL_ZEROS = '0;

    typedef struct packed {
        logic     en;
        rf_addr_t addr;
        word_t    data;
    } rf_wr_cmd_t;

    localparam int RF_WR_NUM_REQ = 2;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational rotating-priority pick starting at i_ptr.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int N     = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    input  logic             i_advance,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    localparam logic [PTR_W:0] c_n = (PTR_W+1)'(N);

    logic [PTR_W-1:0] w_rot_idx [N];

    // Candidate index k positions above the pointer, wrapped modulo N.
    for (genvar k = 0; k < N; k++) begin : g_rot
        logic [PTR_W:0] w_sum;
        assign w_sum        = {1'b0, i_ptr} + (PTR_W+1)'(k);
        assign w_rot_idx[k] = (w_sum >= c_n) ? PTR_W'(w_sum - c_n) : PTR_W'(w_sum);
    end

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_valid && i_advance && i_req[w_rot_idx[k]]) begin
                o_valid = 1'b1;
                o_idx   = w_rot_idx[k];
            end
        end
        if (o_valid) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
// ============================================================================
// Module : rf_wr_arbiter
// Brief  : Round-robin sharing of the register-file write port, X0 absorb,
//          registered write command and saturating contention counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wr_arbiter
    import riscv_32i_defs_pkg::*;
#(
    parameter  int NUM_REQ   = RF_WR_NUM_REQ,
    parameter  int CNT_WIDTH = 16,
    localparam int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             freeze,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*RF_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]          req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             rf_wr_en,
    output logic [RF_ADDR_WIDTH-1:0]         rf_wr_addr,
    output word_t                            rf_wr_data,
    output logic [SRC_W-1:0]                 rf_wr_src,
    output logic [CNT_WIDTH-1:0]             contention_cnt
);

    localparam logic [SRC_W-1:0] c_last = SRC_W'(NUM_REQ - 1);

    rf_addr_t           w_addr [NUM_REQ];
    word_t              w_data [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_x0;
    logic [NUM_REQ-1:0] w_grant;
    logic [SRC_W-1:0]   w_idx;
    logic               w_gnt_valid;
    logic               w_advance;
    logic               w_contended;

    rf_wr_cmd_t           r_cmd;
    logic [SRC_W-1:0]     r_src;
    logic [SRC_W-1:0]     r_ptr;
    logic [CNT_WIDTH-1:0] r_cnt;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign w_addr[i] = req_addr[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
        assign w_data[i] = req_data[i*XLEN +: XLEN];
        assign w_elig[i] = req_valid[i] && (w_addr[i] != X0);
        assign w_x0[i]   = req_valid[i] && (w_addr[i] == X0);
    end

    assign w_advance = rst_n && !freeze;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .i_req     (w_elig),
        .i_ptr     (r_ptr),
        .i_advance (w_advance),
        .o_grant   (w_grant),
        .o_idx     (w_idx),
        .o_valid   (w_gnt_valid)
    );

    // X0 writes are acknowledged immediately and never reach the port.
    assign req_ready = w_advance ? (w_grant | w_x0) : '0;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_contended = !freeze && ((w_elig & (w_elig - NUM_REQ'(1))) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd <= '{en: 1'b0, addr: X0, data: WORD_ALL_ZEROS};
            r_src <= '0;
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            r_cmd.en <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_cmd.addr <= w_addr[w_idx];
                r_cmd.data <= w_data[w_idx];
                r_src      <= w_idx;
                r_ptr      <= (w_idx == c_last) ? '0 : w_idx + 1'b1;
            end
            if (w_contended && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign rf_wr_en       = r_cmd.en;
    assign rf_wr_addr     = r_cmd.addr;
    assign rf_wr_data     = r_cmd.data;
    assign rf_wr_src      = r_src;
    assign contention_cnt = r_cnt;

`ifndef SYNTHESIS
    // Requesters must hold a pending request unchanged until it is accepted.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_hold
        a_req_hold : assert property (
            @(posedge clk) disable iff (!rst_n)
            (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(w_addr[i]) && $stable(w_data[i]))
        );
    end
`endif

endmodule

`default_nettype wire
